ex_muldiv: RTL and testbench
============================

# ex_muldiv

Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the ID/EX pipeline register. It consumes the `rs1`/`rs2` operand values and the M-extension `funct3` that leave ID/EX. It computes one result over a fixed multi-cycle sequence and holds the pipeline via `busy`, which gates the ID/EX `load`. It presents `result` with a one-cycle `done` pulse for capture by EX/MEM.

## Interface
- `XLEN`, 32, operand/result width; only 32 is supported.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `start`  in  1  request a new M-op; decoded by EX from the ID/EX control word.
- `funct3`  in  3  op select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `rs1`  in  32  operand A: multiplicand or dividend.
- `rs2`  in  32  operand B: multiplier or divisor.
- `flush`  in  1  abort the current op, e.g. on a branch mispredict.
- `busy`  out  1  stall request to the hazard logic and the ID/EX `load`.
- `done`  out  1  one-cycle pulse; `result` is valid in this cycle.
- `result`  out  32  computed value; held until the next `done`.

## Operation
- FSM states and transitions:
  - IDLE → PREP when `start` is sampled high.
  - PREP → CALC after 1 cycle.
  - CALC → FIN after 32 cycles.
  - FIN → DONE after 1 cycle.
  - DONE → IDLE after 1 cycle.
- PREP:
  - Latch `funct3` and the operands.
  - Take absolute values where the op is signed: MULH both operands, MULHSU `rs1` only, DIV/REM both.
  - Record the result sign and detect the special cases.
- CALC multiply: radix-2 shift-add on a 64-bit product register, one multiplier bit per cycle, 6-bit iteration counter.
- CALC divide: restoring division on a 33-bit partial remainder, one quotient bit per cycle.
- FIN:
  - Apply two's-complement sign correction.
  - Select the low word (MUL), high word (MULH*), quotient or remainder.
  - Register the selected value into `result`.
- Divide by zero: quotient 0xFFFFFFFF for both DIV and DIVU; remainder = `rs1`.
- Signed overflow (DIV/REM with 0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0.
- Special cases are resolved in FIN and keep the full fixed latency; there is no early exit.
- Sign rules:
  - Quotient is negative when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Magnitudes are computed unsigned in 33 bits to avoid overflow on 0x80000000.

## Timing
- Reset values:
  - State IDLE.
  - `result` = 0, `done` = 0, counter = 0.
  - `busy` forced to 0 while reset is asserted.
- `busy` is combinational: (`start` && IDLE && !`flush`) || state ∈ {PREP, CALC, FIN}.
  - Consequence: the stall begins in the same cycle `start` is raised.
- Latency, with `start` sampled in cycle 0:
  - PREP in cycle 1.
  - CALC in cycles 2–33.
  - FIN in cycle 34.
  - DONE in cycle 35.
- In DONE, `done` = 1 and `busy` = 0, so ID/EX advances and EX/MEM captures `result` on the same edge.
- `start` outside IDLE is ignored.
- `start` held high through DONE does not retrigger until IDLE is reached. Back-to-back ops therefore have one idle cycle between them.
- `flush`:
  - Synchronous; in any state it moves the FSM to IDLE on the next edge.
  - No `done` is produced; `result` keeps its previous value.
- `flush` and `start` in the same IDLE cycle: flush wins, the op is not accepted, and `busy` stays 0.
- `flush` in DONE: the `done` already driven that cycle stands, and the FSM returns to IDLE.
- Reset asserted mid-operation: immediate return to reset values, no `done`.

## Structure
- Add to `rv32i_types`:
  - `muldiv_funct3_t` enum for the eight op encodings.
  - `muldiv_state_t` enum: IDLE, PREP, CALC, FIN, DONE.
  - Constant `MULDIV_ITERS = 32`.
- Single module; the datapath is small enough that no sub-module is warranted.
- EX stage instantiates `ex_muldiv` beside the ALU and muxes `result` into the EX output when the control word marks an M-op.

## Test plan
- MUL, `rs1` = 7, `rs2` = 0xFFFFFFFD (−3), `start` in cycle 0:
  - `busy` high in cycles 0–34.
  - `done` in cycle 35 only, `result` = 0xFFFFFFEB.
- MULH 0x80000000 × 0x80000000 → 0x40000000.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIVU 100/7 → 14.
- REMU 100/7 → 2.
- DIV −7/2 → 0xFFFFFFFD (−3).
- REM −7/2 → 0xFFFFFFFF (−1).
- DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- Flush: start DIVU, assert `flush` in cycle 10:
  - Next cycle is IDLE with `busy` = 0.
  - No `done` is ever seen and `result` is unchanged.
  - A new `start` in cycle 12 completes with `done` in cycle 47.
- Reset low during cycle 20 of an op:
  - `busy`, `done` and `result` go to 0 immediately.
  - After release, a fresh MUL 3×4 → 12 with the standard 35-cycle latency.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32 execute-stage types: M-extension op encodings and the
// multiply/divide sequencer states, plus small two's-complement helpers.
package rv32i_types;

  localparam int MULDIV_ITERS = 32;

  typedef enum logic [2:0] {
    F3_MUL    = 3'd0,
    F3_MULH   = 3'd1,
    F3_MULHSU = 3'd2,
    F3_MULHU  = 3'd3,
    F3_DIV    = 3'd4,
    F3_DIVU   = 3'd5,
    F3_REM    = 3'd6,
    F3_REMU   = 3'd7
  } muldiv_funct3_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIN  = 3'd3,
    S_DONE = 3'd4
  } muldiv_state_t;

  function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: fixed 36-cycle sequence
// (IDLE, PREP, 32x CALC, FIN, DONE) with a combinational pipeline stall.
module ex_muldiv
  import rv32i_types::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [5:0] LAST_ITER = 6'(MULDIV_ITERS - 1);

  muldiv_state_t  state, state_nxt;
  muldiv_funct3_t op;
  logic [31:0] a_raw, b_raw, a_mag, b_mag, rem;
  logic [63:0] prod;
  logic [5:0]  cnt;
  logic        neg_res, div_zero, ovf;

  logic        a_sgn, b_sgn, is_div;
  logic [31:0] a_abs, b_abs, sub, fin_val;
  logic [32:0] sum, shifted;
  logic [63:0] prod_fix;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; flush overrides every state
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state_nxt = S_PREP; else state_nxt = S_IDLE;
        S_PREP:  state_nxt = S_CALC;
        S_CALC:  if (cnt == LAST_ITER) state_nxt = S_FIN; else state_nxt = S_CALC;
        S_FIN:   state_nxt = S_DONE;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Stall output; held low while reset is asserted
  always_comb begin
    busy = 1'b0;
    if (rst) begin
      busy = ((state == S_IDLE) && start && !flush) ||
             (state == S_PREP) || (state == S_CALC) || (state == S_FIN);
    end else begin
      busy = 1'b0;
    end
  end

  // Operand conditioning for PREP: signs, magnitudes, op class
  always_comb begin
    a_sgn  = ((op == F3_MULH) || (op == F3_MULHSU) || (op == F3_DIV) || (op == F3_REM)) && a_raw[31];
    b_sgn  = ((op == F3_MULH) || (op == F3_DIV) || (op == F3_REM)) && b_raw[31];
    a_abs  = cond_neg32(a_raw, a_sgn);
    b_abs  = cond_neg32(b_raw, b_sgn);
    is_div = op[2];
  end

  // One iteration step: shift-add for multiply, restoring subtract for divide
  always_comb begin
    sum     = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, a_mag} : 33'd0);
    shifted = {rem, prod[31]};
    sub     = shifted[31:0] - b_mag;
  end

  // FIN result selection with sign correction and special cases
  always_comb begin
    prod_fix = cond_neg64(prod, neg_res);
    fin_val  = 32'd0;
    case (op)
      F3_MUL:                        fin_val = prod[31:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  fin_val = prod_fix[63:32];
      F3_DIV, F3_DIVU: begin
        if (div_zero)  fin_val = 32'hFFFF_FFFF;
        else if (ovf)  fin_val = 32'h8000_0000;
        else           fin_val = cond_neg32(prod[31:0], neg_res);
      end
      F3_REM, F3_REMU: begin
        if (div_zero)  fin_val = a_raw;
        else if (ovf)  fin_val = 32'd0;
        else           fin_val = cond_neg32(rem, neg_res);
      end
      default:                       fin_val = 32'd0;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op       <= F3_MUL;
      a_raw    <= 32'd0;
      b_raw    <= 32'd0;
      a_mag    <= 32'd0;
      b_mag    <= 32'd0;
      rem      <= 32'd0;
      prod     <= 64'd0;
      cnt      <= 6'd0;
      neg_res  <= 1'b0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
      result   <= 32'd0;
      done     <= 1'b0;
    end else begin
      done <= (state == S_FIN) && !flush;
      case (state)
        S_IDLE: begin
          if (start && !flush) begin
            op    <= muldiv_funct3_t'(funct3);
            a_raw <= rs1;
            b_raw <= rs2;
          end
        end
        S_PREP: begin
          a_mag    <= a_abs;
          b_mag    <= b_abs;
          neg_res  <= (op == F3_REM) ? a_sgn : (a_sgn ^ b_sgn);
          div_zero <= (b_raw == 32'd0);
          ovf      <= ((op == F3_DIV) || (op == F3_REM)) &&
                      (a_raw == 32'h8000_0000) && (b_raw == 32'hFFFF_FFFF);
          prod     <= is_div ? {32'd0, a_abs} : {32'd0, b_abs};
          rem      <= 32'd0;
          cnt      <= 6'd0;
        end
        S_CALC: begin
          cnt <= cnt + 6'd1;
          if (!is_div) begin
            prod <= {sum, prod[31:1]};
          end else if (shifted >= {1'b0, b_mag}) begin
            rem  <= sub;
            prod <= {prod[63:32], prod[30:0], 1'b1};
          end else begin
            rem  <= shifted[31:0];
            prod <= {prod[63:32], prod[30:0], 1'b0};
          end
        end
        S_FIN: begin
          if (!flush) result <= fin_val;
        end
        S_DONE: begin
          cnt <= 6'd0;
        end
        default: begin
          cnt <= 6'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed RV32M cases, timing/flush/reset
// scenarios and random ops against an arithmetic reference model.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic        flush;
  logic        busy, done;
  logic [31:0] result;

  int n_checks = 0;
  int n_errors = 0;

  ex_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: RV32M semantics from plain 64-bit arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    longint unsigned ua, ub, pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin pu = ua * ub; return pu[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        pu = ua / ub; return pu[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        pu = ua % ub; return pu[31:0];
      end
    endcase
  endfunction

  // Entered #1 after a rising edge with the DUT idle; start is cycle 0
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp, got, held;
    int done_cyc, bad;
    exp = ref_model(f, a, b);
    funct3 = f; rs1 = a; rs2 = b; start = 1'b1;
    done_cyc = -1; bad = 0; got = 32'hx; held = 32'hx;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy !== (c <= 34)) bad++;
      if (done === 1'b1) begin
        if (done_cyc < 0) begin done_cyc = c; got = result; end
        else bad++;
      end
      if (c == 39) held = result;
      @(posedge clk); #1;
      start = 1'b0;
    end
    check_eq({tag, " latency"}, done_cyc, 35);
    check_eq({tag, " busy/done profile errs"}, bad, 0);
    check_eq({tag, " result"}, got, exp);
    check_eq({tag, " result held"}, held, exp);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] specials [5];
    specials[0] = 32'h0000_0000; specials[1] = 32'h0000_0001;
    specials[2] = 32'hFFFF_FFFF; specials[3] = 32'h8000_0000;
    specials[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    logic [31:0] prev, got;
    int d1, d2, first_done, early;
    rst = 1'b0; start = 1'b1; flush = 1'b0; funct3 = 3'd0; rs1 = 32'd0; rs2 = 32'd0;

    // Reset values, with start held high to show busy is forced low
    #2;
    check_eq("reset busy", busy, 1'b0);
    check_eq("reset done", done, 1'b0);
    check_eq("reset result", result, 32'd0);
    repeat (2) @(negedge clk);
    start = 1'b0; rst = 1'b1;
    @(posedge clk); #1;

    run_op("MUL 7*-3",        3'd0, 32'd7,        32'hFFFF_FFFD);
    run_op("MULH min*min",    3'd1, 32'h8000_0000, 32'h8000_0000);
    run_op("MULHU max*max",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("MULHSU -1*2",     3'd2, 32'hFFFF_FFFF, 32'd2);
    run_op("DIVU 100/7",      3'd5, 32'd100,       32'd7);
    run_op("REMU 100/7",      3'd7, 32'd100,       32'd7);
    run_op("DIV -7/2",        3'd4, 32'hFFFF_FFF9, 32'd2);
    run_op("REM -7/2",        3'd6, 32'hFFFF_FFF9, 32'd2);
    run_op("DIV 5/0",         3'd4, 32'd5,         32'd0);
    run_op("REM 5/0",         3'd6, 32'd5,         32'd0);
    run_op("DIVU 5/0",        3'd5, 32'd5,         32'd0);
    run_op("DIV ovf",         3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("REM ovf",         3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    check_eq("MUL spot value", ref_model(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);

    // start held high: second op accepted only after one idle cycle
    funct3 = 3'd0; rs1 = 32'd5; rs2 = 32'd6; start = 1'b1;
    d1 = -1; d2 = -1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (d1 < 0) d1 = c; else if (d2 < 0) d2 = c;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check_eq("held start first done", d1, 35);
    check_eq("held start second done", d2, 71);
    repeat (3) @(posedge clk); #1;

    // Flush mid-op, restart in cycle 12
    prev = result; first_done = -1; early = 0; got = 32'h0;
    for (int c = 0; c < 55; c++) begin
      start = (c == 0) || (c == 12);
      flush = (c == 10);
      funct3 = 3'd5;
      rs1 = (c < 12) ? 32'd1000 : 32'hFFFF_FFFF;
      rs2 = (c < 12) ? 32'd3 : 32'd16;
      @(negedge clk);
      if (c == 11) begin
        check_eq("flush busy next cycle", busy, 1'b0);
        check_eq("flush result kept", result, prev);
      end
      if (done === 1'b1) begin
        if (first_done < 0) begin first_done = c; got = result; end
        if (c < 47) early++;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; flush = 1'b0;
    check_eq("flush no early done", early, 0);
    check_eq("restart done cycle", first_done, 47);
    check_eq("restart result", got, 32'h0FFF_FFFF);

    // flush and start together in IDLE: op rejected
    start = 1'b1; flush = 1'b1; funct3 = 3'd0; rs1 = 32'd2; rs2 = 32'd2;
    @(negedge clk);
    check_eq("flush+start busy", busy, 1'b0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    early = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy === 1'b1 || done === 1'b1) early++;
    end
    check_eq("flush+start stays idle", early, 0);
    @(posedge clk); #1;

    // Random ops
    for (int i = 0; i < 30; i++) begin
      logic [2:0] f;
      logic [31:0] a, b;
      f = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      run_op($sformatf("rand%0d f%0d %h %h", i, f, a, b), f, a, b);
    end

    // Reset asserted in cycle 20 of an op
    funct3 = 3'd4; rs1 = 32'd12345; rs2 = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check_eq("midop reset busy", busy, 1'b0);
    check_eq("midop reset done", done, 1'b0);
    check_eq("midop reset result", result, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    run_op("post-reset MUL 3*4", 3'd0, 32'd3, 32'd4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
